cc_goal_row_tracker: RTL and testbench

- Parametrised, registered successor to the goal-row comparator in the Frogger game datapath.
- On each frame strobe, compares the OR-combined goal row against the stored last-register row and detects frog arrivals in goal slots.
- Tracks slot occupancy across frames and runs a PLAY/WIN/LOSE round state machine.
- Feeds the game-control FSM, which acknowledges end of round.

---
 rtl/cc_goal_row_tracker_if.sv | 39 +++
 rtl/cc_goal_row_tracker.sv | 115 +++++++++++
 tb/tb_cc_goal_row_tracker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cc_goal_row_tracker_if.sv
// Frame-strobe bus between the Frogger datapath/game-control FSM and the goal-row tracker.
// The master drives the sampled rows and ack; the slave (tracker) returns the registered round status.
interface cc_goal_row_tracker_if #(
  parameter int GOALROW_DATAWIDTH = 8,
  parameter int GOALROW_CNTWIDTH  = $clog2(GOALROW_DATAWIDTH + 1)
);

  logic                         CC_GoalRowTRACKER_sample_InLow;
  logic                         CC_GoalRowTRACKER_ack_InHigh;
  logic [GOALROW_DATAWIDTH-1:0] CC_GoalRowTRACKER_dataOR_InBUS;
  logic [GOALROW_DATAWIDTH-1:0] CC_GoalRowTRACKER_dataLastRegister_InBUS;
  logic [1:0]                   CC_GoalRowTRACKER_status_OutBUS;
  logic [GOALROW_DATAWIDTH-1:0] CC_GoalRowTRACKER_occupancy_OutBUS;
  logic [GOALROW_CNTWIDTH-1:0]  CC_GoalRowTRACKER_filled_OutBUS;
  logic                         CC_GoalRowTRACKER_event_OutHigh;

  modport master (
    output CC_GoalRowTRACKER_sample_InLow,
    output CC_GoalRowTRACKER_ack_InHigh,
    output CC_GoalRowTRACKER_dataOR_InBUS,
    output CC_GoalRowTRACKER_dataLastRegister_InBUS,
    input  CC_GoalRowTRACKER_status_OutBUS,
    input  CC_GoalRowTRACKER_occupancy_OutBUS,
    input  CC_GoalRowTRACKER_filled_OutBUS,
    input  CC_GoalRowTRACKER_event_OutHigh
  );

  modport slave (
    input  CC_GoalRowTRACKER_sample_InLow,
    input  CC_GoalRowTRACKER_ack_InHigh,
    input  CC_GoalRowTRACKER_dataOR_InBUS,
    input  CC_GoalRowTRACKER_dataLastRegister_InBUS,
    output CC_GoalRowTRACKER_status_OutBUS,
    output CC_GoalRowTRACKER_occupancy_OutBUS,
    output CC_GoalRowTRACKER_filled_OutBUS,
    output CC_GoalRowTRACKER_event_OutHigh
  );

endinterface

// File: rtl/cc_goal_row_tracker.sv
// Registered goal-row tracker: detects frog arrivals in goal slots on each frame strobe,
// keeps slot occupancy across frames and runs the PLAY/WIN/LOSE round state machine.
module cc_goal_row_tracker #(
  parameter int                           GOALROW_DATAWIDTH = 8,
  parameter logic [GOALROW_DATAWIDTH-1:0] GOALROW_SLOTMASK  = {GOALROW_DATAWIDTH{1'b1}},
  parameter int                           GOALROW_CNTWIDTH  = $clog2(GOALROW_DATAWIDTH + 1)
) (
  input logic                   CC_GoalRowTRACKER_CLOCK_50,
  input logic                   CC_GoalRowTRACKER_RESET_InHigh,
  cc_goal_row_tracker_if.slave  trackerBus
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } roundState_e;

  localparam logic [1:0] STATUS_NONE   = 2'b00;
  localparam logic [1:0] STATUS_FILLED = 2'b01;
  localparam logic [1:0] STATUS_WIN    = 2'b11;
  localparam logic [1:0] STATUS_LOSE   = 2'b10;

  roundState_e                  roundState;
  logic [GOALROW_DATAWIDTH-1:0] occupancyReg;
  logic [GOALROW_CNTWIDTH-1:0]  filledReg;
  logic [1:0]                   statusReg;
  logic                         eventReg;

  logic [GOALROW_DATAWIDTH-1:0] arrivals;
  logic [GOALROW_DATAWIDTH-1:0] occNext;
  logic [GOALROW_CNTWIDTH-1:0]  filledNext;
  logic                         hitWall;
  logic                         hitFull;
  logic                         allOnes;
  logic                         slotsComplete;
  logic                         rowChanged;

  function automatic logic [GOALROW_CNTWIDTH-1:0] popCount(input logic [GOALROW_DATAWIDTH-1:0] bits);
    logic [GOALROW_CNTWIDTH-1:0] count;
    count = '0;
    for (int i = 0; i < GOALROW_DATAWIDTH; i++) begin
      count = count + GOALROW_CNTWIDTH'(bits[i]);
    end
    return count;
  endfunction

  // Occupancy only ever holds slot columns, so recounting the next map equals adding the
  // popcount of legal arrivals and can never exceed the number of slots.
  always_comb begin
    arrivals      = trackerBus.CC_GoalRowTRACKER_dataOR_InBUS
                    & ~trackerBus.CC_GoalRowTRACKER_dataLastRegister_InBUS;
    hitWall       = |(arrivals & ~GOALROW_SLOTMASK);
    hitFull       = |(arrivals & occupancyReg);
    occNext       = occupancyReg | (arrivals & GOALROW_SLOTMASK);
    filledNext    = popCount(occNext);
    allOnes       = &trackerBus.CC_GoalRowTRACKER_dataOR_InBUS;
    slotsComplete = ((occNext & GOALROW_SLOTMASK) == GOALROW_SLOTMASK)
                    && (|arrivals) && !hitWall && !hitFull;
    rowChanged    = trackerBus.CC_GoalRowTRACKER_dataOR_InBUS
                    != trackerBus.CC_GoalRowTRACKER_dataLastRegister_InBUS;
  end

  // Round FSM with registered outputs; reset beats ack, ack beats a same-cycle sample,
  // and WIN/LOSE stay put until the game-control FSM acknowledges.
  always_ff @(posedge CC_GoalRowTRACKER_CLOCK_50) begin
    if (CC_GoalRowTRACKER_RESET_InHigh || trackerBus.CC_GoalRowTRACKER_ack_InHigh) begin
      roundState   <= PLAY;
      occupancyReg <= '0;
      filledReg    <= '0;
      statusReg    <= STATUS_NONE;
      eventReg     <= 1'b0;
    end else begin
      eventReg <= 1'b0;
      case (roundState)
        PLAY: begin
          if (trackerBus.CC_GoalRowTRACKER_sample_InLow) begin
            if (allOnes || slotsComplete) begin
              occupancyReg <= occNext;
              filledReg    <= filledNext;
              statusReg    <= STATUS_WIN;
              eventReg     <= 1'b1;
              roundState   <= WIN;
            end else if (hitWall || hitFull) begin
              statusReg  <= STATUS_LOSE;
              eventReg   <= 1'b1;
              roundState <= LOSE;
            end else if (|arrivals) begin
              occupancyReg <= occNext;
              filledReg    <= filledNext;
              statusReg    <= STATUS_FILLED;
              eventReg     <= 1'b1;
            end else if (rowChanged) begin
              statusReg <= STATUS_FILLED;
              eventReg  <= 1'b1;
            end else begin
              statusReg <= STATUS_NONE;
            end
          end
        end
        WIN, LOSE: begin
        end
        default: begin
          roundState <= PLAY;
        end
      endcase
    end
  end

  assign trackerBus.CC_GoalRowTRACKER_status_OutBUS    = statusReg;
  assign trackerBus.CC_GoalRowTRACKER_occupancy_OutBUS = occupancyReg;
  assign trackerBus.CC_GoalRowTRACKER_filled_OutBUS    = filledReg;
  assign trackerBus.CC_GoalRowTRACKER_event_OutHigh    = eventReg;

endmodule

// File: tb/tb_cc_goal_row_tracker.sv
// Directed bench for cc_goal_row_tracker: one instance with every column a slot (mask FF) and
// one with walls between slots (mask 55), both driven by the same frame vectors.
module tb_cc_goal_row_tracker;

  localparam int W = 8;
  localparam int C = $clog2(W + 1);

  logic clock;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  cc_goal_row_tracker_if #(.GOALROW_DATAWIDTH(W), .GOALROW_CNTWIDTH(C)) fullBus ();
  cc_goal_row_tracker_if #(.GOALROW_DATAWIDTH(W), .GOALROW_CNTWIDTH(C)) slotBus ();

  cc_goal_row_tracker #(
    .GOALROW_DATAWIDTH(W),
    .GOALROW_SLOTMASK (8'hFF),
    .GOALROW_CNTWIDTH (C)
  ) dutFull (
    .CC_GoalRowTRACKER_CLOCK_50    (clock),
    .CC_GoalRowTRACKER_RESET_InHigh(reset),
    .trackerBus                    (fullBus)
  );

  cc_goal_row_tracker #(
    .GOALROW_DATAWIDTH(W),
    .GOALROW_SLOTMASK (8'h55),
    .GOALROW_CNTWIDTH (C)
  ) dutSlot (
    .CC_GoalRowTRACKER_CLOCK_50    (clock),
    .CC_GoalRowTRACKER_RESET_InHigh(reset),
    .trackerBus                    (slotBus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkFull(input string tag, input logic [1:0] status, input logic eventBit,
                           input logic [7:0] occupancy, input logic [3:0] filled);
    checkOutput({"full ", tag, " status"},    32'(fullBus.CC_GoalRowTRACKER_status_OutBUS),    32'(status));
    checkOutput({"full ", tag, " event"},     32'(fullBus.CC_GoalRowTRACKER_event_OutHigh),    32'(eventBit));
    checkOutput({"full ", tag, " occupancy"}, 32'(fullBus.CC_GoalRowTRACKER_occupancy_OutBUS), 32'(occupancy));
    checkOutput({"full ", tag, " filled"},    32'(fullBus.CC_GoalRowTRACKER_filled_OutBUS),    32'(filled));
  endtask

  task automatic checkSlot(input string tag, input logic [1:0] status, input logic eventBit,
                           input logic [7:0] occupancy, input logic [3:0] filled);
    checkOutput({"slot ", tag, " status"},    32'(slotBus.CC_GoalRowTRACKER_status_OutBUS),    32'(status));
    checkOutput({"slot ", tag, " event"},     32'(slotBus.CC_GoalRowTRACKER_event_OutHigh),    32'(eventBit));
    checkOutput({"slot ", tag, " occupancy"}, 32'(slotBus.CC_GoalRowTRACKER_occupancy_OutBUS), 32'(occupancy));
    checkOutput({"slot ", tag, " filled"},    32'(slotBus.CC_GoalRowTRACKER_filled_OutBUS),    32'(filled));
  endtask

  // Drive one cycle of inputs on the falling edge; outputs are then valid 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic sample, input logic ack,
                               input logic [7:0] dataOR, input logic [7:0] dataLast);
    @(negedge clock);
    reset = rst;
    fullBus.CC_GoalRowTRACKER_sample_InLow           = sample;
    fullBus.CC_GoalRowTRACKER_ack_InHigh             = ack;
    fullBus.CC_GoalRowTRACKER_dataOR_InBUS           = dataOR;
    fullBus.CC_GoalRowTRACKER_dataLastRegister_InBUS = dataLast;
    slotBus.CC_GoalRowTRACKER_sample_InLow           = sample;
    slotBus.CC_GoalRowTRACKER_ack_InHigh             = ack;
    slotBus.CC_GoalRowTRACKER_dataOR_InBUS           = dataOR;
    slotBus.CC_GoalRowTRACKER_dataLastRegister_InBUS = dataLast;
    @(posedge clock);
    #1;
    reset = 1'b0;
    fullBus.CC_GoalRowTRACKER_sample_InLow = 1'b0;
    fullBus.CC_GoalRowTRACKER_ack_InHigh   = 1'b0;
    slotBus.CC_GoalRowTRACKER_sample_InLow = 1'b0;
    slotBus.CC_GoalRowTRACKER_ack_InHigh   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    fullBus.CC_GoalRowTRACKER_sample_InLow           = 1'b0;
    fullBus.CC_GoalRowTRACKER_ack_InHigh             = 1'b0;
    fullBus.CC_GoalRowTRACKER_dataOR_InBUS           = '0;
    fullBus.CC_GoalRowTRACKER_dataLastRegister_InBUS = '0;
    slotBus.CC_GoalRowTRACKER_sample_InLow           = 1'b0;
    slotBus.CC_GoalRowTRACKER_ack_InHigh             = 1'b0;
    slotBus.CC_GoalRowTRACKER_dataOR_InBUS           = '0;
    slotBus.CC_GoalRowTRACKER_dataLastRegister_InBUS = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkFull("reset", 2'b00, 1'b0, 8'h00, 4'd0);
    checkSlot("reset", 2'b00, 1'b0, 8'h00, 4'd0);

    // Unchanged row: nothing to report.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C);
    checkFull("noChange", 2'b00, 1'b0, 8'h00, 4'd0);
    checkSlot("noChange", 2'b00, 1'b0, 8'h00, 4'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    checkFull("arrive0", 2'b01, 1'b1, 8'h01, 4'd1);
    checkSlot("arrive0", 2'b01, 1'b1, 8'h01, 4'd1);

    // No strobe: status holds, event drops.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    checkSlot("idleHold", 2'b01, 1'b0, 8'h01, 4'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h01);
    checkFull("arrive2", 2'b01, 1'b1, 8'h05, 4'd2);
    checkSlot("arrive2", 2'b01, 1'b1, 8'h05, 4'd2);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    checkSlot("arrive4", 2'b01, 1'b1, 8'h15, 4'd3);

    // Last free slot completes the 0x55 row; the FF row still has gaps.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
    checkSlot("winFill", 2'b11, 1'b1, 8'h55, 4'd4);
    checkFull("partFill", 2'b01, 1'b1, 8'h55, 4'd4);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
    checkSlot("winSticky", 2'b11, 1'b0, 8'h55, 4'd4);
    checkFull("arrive1", 2'b01, 1'b1, 8'h57, 4'd5);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checkSlot("ackWin", 2'b00, 1'b0, 8'h00, 4'd0);
    checkFull("ackPlay", 2'b00, 1'b0, 8'h00, 4'd0);

    // Column 1 is a wall under mask 55 but a slot under mask FF.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
    checkSlot("wallHit", 2'b10, 1'b1, 8'h00, 4'd0);
    checkFull("wallCol", 2'b01, 1'b1, 8'h02, 4'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    checkSlot("loseSticky", 2'b10, 1'b0, 8'h00, 4'd0);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    checkSlot("ackLose", 2'b00, 1'b0, 8'h00, 4'd0);
    checkFull("ackLose", 2'b00, 1'b0, 8'h00, 4'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    checkSlot("refill", 2'b01, 1'b1, 8'h01, 4'd1);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    checkSlot("fullHit", 2'b10, 1'b1, 8'h01, 4'd1);
    checkFull("fullHit", 2'b10, 1'b1, 8'h01, 4'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

    // All-ones row wins even though it also lands on walls.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 8'h12);
    checkSlot("allOnes", 2'b11, 1'b1, 8'h45, 4'd3);
    checkFull("allOnes", 2'b11, 1'b1, 8'hED, 4'd6);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
    checkSlot("ackSample", 2'b00, 1'b0, 8'h00, 4'd0);
    checkFull("ackSample", 2'b00, 1'b0, 8'h00, 4'd0);

    // Row changed but no new frog bit.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
    checkSlot("changeOnly", 2'b01, 1'b1, 8'h00, 4'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    checkSlot("winAgain", 2'b11, 1'b1, 8'h55, 4'd4);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
    checkSlot("resetInWin", 2'b00, 1'b0, 8'h00, 4'd0);
    checkFull("resetInWin", 2'b00, 1'b0, 8'h00, 4'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    checkSlot("playAfterReset", 2'b01, 1'b1, 8'h01, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
